al_accel_wbuf_kxk: RTL

Parametrised K×K weight shift buffer for the convolution accelerator datapath. It loads a full kernel of K·K weight elements from the 32-bit-class bus through a valid/ready handshake with an auto-incrementing element pointer. It then shifts the kernel one element per cycle toward index 0 and presents the K row-head elements to the MAC array as taps. It is the successor of the fixed 3×3, 8-bit bank/strobe weight buffer: geometry is generic, load is flow-controlled, and it adds fill tracking and clear.

---
 rtl/al_accel_pkg.sv | 14 +
 rtl/al_accel_wbuf_kxk_if.sv | 11 +
 rtl/al_accel_wbuf_kxk.sv | 98 +++++++++
 3 files changed

// File: rtl/al_accel_pkg.sv
// Shared accelerator package: buffer state encoding and pointer sizing helper.
package al_accel_pkg;

    typedef enum logic {
        WBUF_LOAD = 1'b0,
        WBUF_FULL = 1'b1
    } wbuf_state_e;

    // Pointer must be able to hold the value n (one past the last index).
    function automatic int ptr_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/al_accel_wbuf_kxk_if.sv
// Flow-controlled load bus feeding the weight buffer.
interface al_accel_wbuf_kxk_if #(
    parameter int BUSW = 32
) ();
    logic            ld_valid;
    logic            ld_ready;
    logic [BUSW-1:0] ld_data;

    modport master (output ld_valid, output ld_data, input  ld_ready);
    modport slave  (input  ld_valid, input  ld_data, output ld_ready);
endinterface

// File: rtl/al_accel_wbuf_kxk.sv
// KxK weight shift buffer: word-wise kernel load, then element-wise shift toward index 0
// with one tap per kernel row head.
module al_accel_wbuf_kxk
    import al_accel_pkg::*;
#(
    parameter int K    = 3,
    parameter int DW   = 8,
    parameter int BUSW = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enb,
    input  logic                 wbuf_clr,
    al_accel_wbuf_kxk_if.slave   ld,
    input  logic                 shift_en,
    input  logic [DW-1:0]        shift_in,
    output logic                 wbuf_full,
    output logic [K*DW-1:0]      wbuf_tap
);

    localparam int N   = K * K;
    localparam int BPW = BUSW / DW;
    localparam int PW  = ptr_w(N);

    wbuf_state_e              r_state, w_state_nxt;
    logic [PW-1:0]            r_ptr;
    logic [N-1:0][DW-1:0]     r_elem;
    logic [N-1:0][DW-1:0]     w_din;
    logic [N-1:0]             w_we;
    logic [31:0]              w_ptr_sum;
    logic                     w_ptr_full;
    logic                     w_ld_ready;
    logic                     w_ld_fire;
    logic                     w_shift;

    assign w_ptr_sum  = 32'(r_ptr) + 32'(BPW);
    assign w_ptr_full = (w_ptr_sum >= 32'(N));

    // ld_ready depends only on state, enable and reset, never on ld_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        w_ld_fire   = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            WBUF_LOAD: begin
                w_ld_ready = resetn & enb;
                w_ld_fire  = ld.ld_valid & w_ld_ready & ~wbuf_clr;
                if (w_ld_fire && w_ptr_full)
                    w_state_nxt = WBUF_FULL;
            end
            WBUF_FULL: w_shift = shift_en & enb & ~wbuf_clr;
            default:   w_state_nxt = WBUF_LOAD;
        endcase
        if (wbuf_clr)
            w_state_nxt = WBUF_LOAD;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= WBUF_LOAD;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        r_ptr <= '0;
        else if (wbuf_clr)  r_ptr <= '0;
        else if (w_ld_fire) r_ptr <= w_ptr_full ? PW'(N) : PW'(w_ptr_sum);
    end

    // Element i takes lane (i - ptr) when that lane exists in the current word;
    // lanes landing at or beyond N have no element and are dropped.
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
        logic [31:0] w_off;
        assign w_off     = 32'(gi) - 32'(r_ptr);
        assign w_we[gi]  = w_ld_fire && (w_off < 32'(BPW));
        assign w_din[gi] = DW'(ld.ld_data >> (w_off * 32'(DW)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_elem <= '0;
        else if (wbuf_clr)
            r_elem <= '0;
        else if (w_shift)
            r_elem <= {shift_in, r_elem[N-1:1]};
        else
            for (int i = 0; i < N; i++)
                if (w_we[i]) r_elem[i] <= w_din[i];
    end

    for (genvar gr = 0; gr < K; gr++) begin : g_tap
        assign wbuf_tap[gr*DW +: DW] = r_elem[gr*K];
    end

    assign ld.ld_ready = w_ld_ready;
    assign wbuf_full   = (r_state == WBUF_FULL);

endmodule
